// File: rtl/sdio_pkg.sv
// Shared SDIO definitions: bus-width encodings, CRC16 polynomial and the
// receive-frame state encodings.
package sdio_pkg;

  localparam logic SDIO_W1 = 1'b0;
  localparam logic SDIO_W4 = 1'b1;

  localparam logic [15:0] SDIO_CRC_POLY = 16'h1021;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    DATA       = 3'd2,
    CRC        = 3'd3,
    ENDBIT     = 3'd4,
    DONE       = 3'd5
  } rx_state_t;

endpackage

// File: rtl/sdio_crc16.sv
// Single-lane serial CRC16 (x^16+x^12+x^5+1, initial value 0). A frame whose
// data and trailing CRC bits have all been shifted in leaves a zero remainder.
import sdio_pkg::*;

module sdio_crc16 (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_clr,
  input  logic        i_shift,
  input  logic        i_bit,
  output logic [15:0] o_crc
);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_crc <= 16'h0;
    end else if (i_clr) begin
      o_crc <= 16'h0;
    end else if (i_shift) begin
      o_crc <= {o_crc[14:0], 1'b0} ^ ((i_bit ^ o_crc[15]) ? SDIO_CRC_POLY : 16'h0);
    end
  end

endmodule

// File: rtl/sdio_rxframe.sv
// Host-side SDIO data-block receiver: start-bit search, 1/4-bit word packing,
// per-lane CRC16 and end-bit check. Start-bit timeout: SDIO_RXFRAME_TIMEOUT_EN.
import sdio_pkg::*;

module sdio_rxframe #(
  parameter int LGTIMEOUT       = 20,
  parameter int OPT_DEFAULT_LEN = 512
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_en,
  input  logic        i_width,
  input  logic [15:0] i_len,
  input  logic        i_pedge,
  input  logic [3:0]  i_dat,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic        o_last,
  output logic        o_done,
  output logic        o_err,
  output logic        o_timeout,
  output logic [2:0]  o_state
);

  localparam logic [13:0] DEF_WORDS = 14'(OPT_DEFAULT_LEN / 4);

  rx_state_t   state, state_nxt;
  logic        en_q;
  logic        width_q;
  logic [13:0] words_left;
  logic [4:0]  cnt;
  logic [31:0] sreg;
  logic [15:0] crc_rem [4];

  logic        arm, strobe, start_hit, sample_last, crc_bad, end_bad, tmo_hit, crc_shift;
  logic [31:0] word_in;
  logic        unused_len;

  assign arm         = i_en & ~en_q;
  // An abort (i_en low) discards any strobe on the same cycle.
  assign strobe      = i_pedge & i_en;
  assign start_hit   = (width_q == SDIO_W4) ? (i_dat == 4'h0) : ~i_dat[0];
  assign sample_last = (width_q == SDIO_W4) ? (cnt == 5'd7) : (cnt == 5'd31);
  assign word_in     = (width_q == SDIO_W4) ? {sreg[27:0], i_dat} : {sreg[30:0], i_dat[0]};
  assign end_bad     = (width_q == SDIO_W4) ? (i_dat != 4'hF) : ~i_dat[0];
  assign crc_bad     = (|crc_rem[0]) |
                       ((width_q == SDIO_W4) & ((|crc_rem[1]) | (|crc_rem[2]) | (|crc_rem[3])));
  assign crc_shift   = strobe & ((state == DATA) | (state == CRC));
  assign unused_len  = ^i_len[1:0];
  assign o_state     = state;

`ifdef SDIO_RXFRAME_TIMEOUT_EN
  logic [LGTIMEOUT-1:0] tmo_cnt;
  logic                 tmo_flag;
  assign tmo_hit   = (tmo_cnt == '1);
  assign o_timeout = tmo_flag;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      tmo_flag <= 1'b0;
      if (state == IDLE && arm)
        tmo_cnt <= '0;
      else if (state == WAIT_START && strobe)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (state == WAIT_START && tmo_hit && i_en)
        tmo_flag <= 1'b1;
    end
  end
`else
  logic [LGTIMEOUT-1:0] unused_tmo;
  assign unused_tmo = '0;
  assign tmo_hit    = 1'b0;
  assign o_timeout  = 1'b0;
`endif

  for (genvar k = 0; k < 4; k++) begin : g_lane
    sdio_crc16 u_crc (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clr     ((state == IDLE) & arm),
      .i_shift   (crc_shift & ((k == 0) | (width_q == SDIO_W4))),
      .i_bit     (i_dat[k]),
      .o_crc     (crc_rem[k])
    );
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (arm) state_nxt = WAIT_START;
      WAIT_START: if (tmo_hit) state_nxt = DONE;
                  else if (strobe && start_hit) state_nxt = DATA;
      DATA:       if (strobe && sample_last && words_left == 14'd1) state_nxt = CRC;
      CRC:        if (strobe && cnt == 5'd15) state_nxt = ENDBIT;
      ENDBIT:     if (strobe) state_nxt = DONE;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
    if (!i_en && state != IDLE) state_nxt = IDLE;
  end

  // o_valid carries no ready: the consumer takes every one-cycle pulse.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      en_q       <= 1'b0;
      width_q    <= SDIO_W1;
      words_left <= 14'd0;
      cnt        <= 5'd0;
      sreg       <= 32'h0;
      o_valid    <= 1'b0;
      o_data     <= 32'h0;
      o_last     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      en_q    <= i_en;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
      case (state)
        IDLE: if (arm) begin
          width_q    <= i_width;
          words_left <= (i_len[15:2] == 14'd0) ? DEF_WORDS : i_len[15:2];
          cnt        <= 5'd0;
        end
        WAIT_START: begin
          if (strobe) cnt <= 5'd0;
          if (tmo_hit && i_en) begin
            o_done <= 1'b1;
            o_err  <= 1'b1;
          end
        end
        DATA: if (strobe) begin
          sreg <= word_in;
          cnt  <= sample_last ? 5'd0 : cnt + 5'd1;
          if (sample_last) begin
            o_valid    <= 1'b1;
            o_data     <= word_in;
            o_last     <= (words_left == 14'd1);
            words_left <= words_left - 14'd1;
          end
        end
        CRC: if (strobe) cnt <= cnt + 5'd1;
        ENDBIT: if (strobe) begin
          o_done <= 1'b1;
          o_err  <= crc_bad | end_bad;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdio_rxframe.sv
// Self-checking bench for sdio_rxframe: scoreboard of expected words and
// done status, frames built from a byte payload with model-computed CRCs.
`timescale 1ns/1ps
module tb_sdio_rxframe;

`ifdef SDIO_RXFRAME_TIMEOUT_EN
  localparam int LGT = 4;
`else
  localparam int LGT = 20;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_en = 1'b0;
  logic        i_width = 1'b0;
  logic [15:0] i_len = 16'h0;
  logic        i_pedge = 1'b0;
  logic [3:0]  i_dat = 4'hF;
  logic        o_valid, o_last, o_done, o_err, o_timeout;
  logic [31:0] o_data;
  logic [2:0]  o_state;

  sdio_rxframe #(.LGTIMEOUT(LGT), .OPT_DEFAULT_LEN(512)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_en(i_en), .i_width(i_width),
    .i_len(i_len), .i_pedge(i_pedge), .i_dat(i_dat), .o_valid(o_valid),
    .o_data(o_data), .o_last(o_last), .o_done(o_done), .o_err(o_err),
    .o_timeout(o_timeout), .o_state(o_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [32:0] exp_q[$];
  logic [1:0]  done_q[$];
  logic [7:0]  pay [0:511];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // scoreboard
  always @(negedge i_clk) begin
    if (i_reset_n) begin
      if (o_valid) begin
        if (exp_q.size() == 0) check_eq("spurious_valid", 1, 0);
        else check_eq("word", {o_last, o_data}, exp_q.pop_front());
      end
      if (o_done) begin
        done_cnt++;
        if (done_q.size() == 0) check_eq("spurious_done", 1, 0);
        else check_eq("done_status", {o_err, o_timeout}, done_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] d);
    if ($urandom_range(0, 3) == 0) begin
      i_pedge = 1'b0;
      tick();
    end
    i_pedge = 1'b1;
    i_dat   = d;
    tick();
    i_pedge = 1'b0;
    i_dat   = 4'hF;
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h1021 : 16'h0);
  endfunction

  task automatic arm(input logic w, input logic [15:0] len);
    i_en = 1'b0;
    tick();
    tick();
    i_en    = 1'b1;
    i_width = w;
    i_len   = len;
    tick();
  endtask

  task automatic fill_counting();
    for (int i = 0; i < 512; i++) pay[i] = 8'(i);
  endtask

  task automatic push_counting_words(input int nwords, input bit last_on_final);
    for (int w = 0; w < nwords; w++)
      exp_q.push_back({last_on_final && (w == nwords - 1), 8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)});
  endtask

  task automatic send_frame(input logic w, input int nbytes, input int flip_lane,
                            input int flip_bit, input bit bad_end, input int abort_words);
    logic [15:0] lc [4];
    logic [3:0]  d;
    for (int k = 0; k < 4; k++) lc[k] = 16'h0;
    strobe(4'hF);
    strobe(w ? 4'h5 : 4'h1);
    strobe(w ? 4'h0 : 4'hE);
    for (int b = 0; b < nbytes; b++) begin
      if (w) begin
        for (int h = 1; h >= 0; h--) begin
          d = (h == 1) ? pay[b][7:4] : pay[b][3:0];
          for (int k = 0; k < 4; k++) lc[k] = crc_step(lc[k], d[k]);
          strobe(d);
        end
      end else begin
        for (int j = 7; j >= 0; j--) begin
          d = {3'b111, pay[b][j]};
          lc[0] = crc_step(lc[0], d[0]);
          strobe(d);
        end
      end
      if (abort_words > 0 && (b + 1) == 4 * abort_words) begin
        i_en = 1'b0;
        repeat (4) tick();
        return;
      end
    end
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 4; k++) begin
        d[k] = (w || k == 0) ? lc[k][15-i] : 1'b1;
        if (flip_lane == k && flip_bit == i) d[k] = ~d[k];
      end
      strobe(d);
    end
    strobe(bad_end ? 4'hE : 4'hF);
    repeat (4) tick();
    i_en = 1'b0;
    tick();
  endtask

  initial begin : main
    int base;
    repeat (3) tick();
    check_eq("rst_valid", o_valid, 0);
    check_eq("rst_data", o_data, 0);
    check_eq("rst_last", o_last, 0);
    check_eq("rst_done", o_done, 0);
    check_eq("rst_err", o_err, 0);
    check_eq("rst_timeout", o_timeout, 0);
    check_eq("rst_state", o_state, 0);
    i_reset_n = 1'b1;
    tick();

    // 1-bit, 512 bytes, counting payload
    fill_counting();
    push_counting_words(128, 1'b1);
    done_q.push_back(2'b00);
    arm(1'b0, 16'd512);
    send_frame(1'b0, 512, -1, 0, 1'b0, 0);

    // 4-bit, 8 bytes DEADBEEF 01234567
    pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
    pay[4] = 8'h01; pay[5] = 8'h23; pay[6] = 8'h45; pay[7] = 8'h67;
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    exp_q.push_back({1'b1, 32'h01234567});
    done_q.push_back(2'b00);
    arm(1'b1, 16'd8);
    send_frame(1'b1, 8, -1, 0, 1'b0, 0);

    // same frame, one CRC bit flipped on DAT2
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    exp_q.push_back({1'b1, 32'h01234567});
    done_q.push_back(2'b10);
    arm(1'b1, 16'd8);
    send_frame(1'b1, 8, 2, 7, 1'b0, 0);

    // 1-bit, end bit driven 0
    fill_counting();
    push_counting_words(2, 1'b1);
    done_q.push_back(2'b10);
    arm(1'b0, 16'd8);
    send_frame(1'b0, 8, -1, 0, 1'b1, 0);

    // 4-bit, i_len=0 selects the 512-byte default
    push_counting_words(128, 1'b1);
    done_q.push_back(2'b00);
    arm(1'b1, 16'd0);
    send_frame(1'b1, 512, -1, 0, 1'b0, 0);

    // abort after 3 words, then a good re-armed 8-byte frame
    base = done_cnt;
    push_counting_words(3, 1'b0);
    arm(1'b0, 16'd32);
    send_frame(1'b0, 32, -1, 0, 1'b0, 3);
    check_eq("abort_no_done", done_cnt, base);
    check_eq("abort_idle", o_state, 0);
    push_counting_words(2, 1'b1);
    done_q.push_back(2'b00);
    arm(1'b0, 16'd8);
    send_frame(1'b0, 8, -1, 0, 1'b0, 0);
    check_eq("rearm_done", done_cnt, base + 1);

    // reset mid-frame
    arm(1'b0, 16'd8);
    strobe(4'hE);
    repeat (10) strobe(4'hF);
    i_reset_n = 1'b0;
    tick();
    check_eq("midrst_state", o_state, 0);
    check_eq("midrst_valid", o_valid, 0);
    i_reset_n = 1'b1;
    i_en = 1'b0;
    tick();

    // start-bit timeout
    base = done_cnt;
`ifdef SDIO_RXFRAME_TIMEOUT_EN
    done_q.push_back(2'b11);
    arm(1'b0, 16'd8);
    repeat (14) strobe(4'hF);
    repeat (3) tick();
    check_eq("tmo_early", done_cnt, base);
    strobe(4'hF);
    for (int i = 0; i < 10 && done_cnt == base; i++) tick();
    check_eq("tmo_done", done_cnt, base + 1);
`else
    arm(1'b0, 16'd8);
    repeat (1000) strobe(4'hF);
    repeat (3) tick();
    check_eq("no_tmo_done", done_cnt, base);
`endif
    i_en = 1'b0;
    repeat (3) tick();

    check_eq("exp_q_empty", exp_q.size(), 0);
    check_eq("done_q_empty", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdio_rxframe.md
# sdio_rxframe

Host-side SDIO data-block receiver, directly downstream of the card's data transmitter on DAT[3:0]. Samples the DAT lines on host-supplied sample strobes and finds the start bit. Packs 1-bit or 4-bit serial data into big-endian 32-bit words, checks the per-lane CRC16 and end bit, and reports a single done/error status per block. Its output feeds the host's block buffer or DMA.

## Interface
Parameters:
- LGTIMEOUT, 20: log2 of the start-bit timeout, counted in sample strobes. Used only when the timeout feature is compiled in.
- OPT_DEFAULT_LEN, 512: block length in bytes used when i_len is zero.

Ports:
- i_clk  in  1  system clock. One clock domain. All logic is on the rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_en  in  1  receive enable. Rising edge arms the receiver. Deassertion aborts any frame in progress.
- i_width  in  1  bus width: 0 = 1-bit (DAT0 only), 1 = 4-bit. Latched when armed.
- i_len  in  16  block length in bytes. Latched when armed. Bits [1:0] are ignored. Zero selects OPT_DEFAULT_LEN.
- i_pedge  in  1  sample strobe. DAT is sampled only on cycles where this is high.
- i_dat  in  4  DAT[3:0] as sampled from the pads.
- o_valid  out  1  one-cycle pulse: o_data holds a complete word.
- o_data  out  32  received word. The first byte on the wire is in [31:24].
- o_last  out  1  high together with o_valid on the final word of the block.
- o_done  out  1  one-cycle pulse: the frame has finished (good, bad, or timed out).
- o_err  out  1  valid with o_done: CRC mismatch, end-bit error, or timeout.
- o_timeout  out  1  valid with o_done: the start bit never arrived.

## Operation
States: IDLE, WAIT_START, DATA, CRC, ENDBIT, DONE.
- IDLE
  - i_en high with i_en low on the previous cycle latches i_width and the word count (i_len[15:2]), clears the CRCs, and goes to WAIT_START.
- WAIT_START
  - On i_pedge, a start is detected when i_dat[0]==0 in 1-bit mode, or when i_dat==4'h0 in 4-bit mode. Start detection goes to DATA.
  - In 4-bit mode, a partial start (some lanes low, not all) is ignored.
- DATA
  - Each strobe shifts in 1 bit (DAT0) or 1 nibble (DAT[3:0], DAT3 = most significant bit).
  - A word is complete after 32 samples (1-bit mode) or 8 samples (4-bit mode). Each completed word emits o_valid.
  - The final word sets o_last and moves to CRC.
- CRC
  - 16 strobes. Each active lane shifts its received bit into its CRC16 register, polynomial x^16+x^12+x^5+1, initial value 0.
  - Data bits go through the same registers during DATA.
  - Inactive lanes are ignored.
- ENDBIT
  - One strobe. Every active lane must read 1; otherwise the end-bit error flag is set. Then go to DONE.
- DONE
  - o_done is pulsed. o_err = any active-lane CRC remainder nonzero OR end-bit error. Return to IDLE.
  - Re-arming requires i_en to fall and rise again.
- Abort
  - i_en low in any state other than IDLE returns to IDLE on the next clock. No o_done is produced. Outputs already emitted are not retracted.
- Reset
  - Reset forces IDLE at any time, including mid-frame.
  - o_valid, o_last, o_done, o_err and o_timeout all reset to 0; o_data resets to 32'h0.
- No backpressure
  - The consumer must accept o_valid on every pulse.

## Timing
- Sampling happens only on i_pedge cycles. Non-strobe cycles hold all state.
- o_valid/o_data/o_last are registered and asserted on the cycle after the strobe that completes the word.
- o_done/o_err are asserted on the cycle after the end-bit strobe, for exactly one cycle.
- Minimum strobe spacing is 1 cycle, so i_pedge may be held high continuously. Back-to-back o_valid pulses are then 8 cycles apart in 4-bit mode.
- If i_en falls on the same cycle as a strobe, the abort wins and the sample is discarded.
- If i_en rises on the same cycle as a strobe, the strobe is not sampled. Start search begins on the next strobe.

## Configuration
- SDIO_RXFRAME_TIMEOUT_EN defined:
  - A counter of width LGTIMEOUT counts strobes in WAIT_START.
  - At all-ones the block goes to DONE and pulses o_done with o_err=1 and o_timeout=1.
  - The counter clears on arming.
- Undefined:
  - WAIT_START waits indefinitely. o_timeout is tied to 0 and no counter is built.

## Structure
- Shared package sdio_pkg holds:
  - the width encodings (SDIO_W1=1'b0, SDIO_W4=1'b1);
  - the CRC16 polynomial constant 16'h1021;
  - the state enum encodings for this block.
- Sub-module sdio_crc16: a single-lane serial CRC16 with clear, shift-enable and data-bit inputs, and a 16-bit remainder output. Four instances are generated; lanes 1-3 are enabled only in 4-bit mode.

## Test plan
- 1-bit mode, i_len=512, counting-byte payload 00,01,..,FF,00.. with correct CRC -> 128 o_valid pulses:
  - first o_data=32'h00010203;
  - o_last on word 128 = 32'hFCFDFEFF;
  - o_done with o_err=0.
- 4-bit mode, i_len=8, payload DEADBEEF 01234567 with correct per-lane CRCs:
  - o_data=32'hDEADBEEF, then 32'h01234567 with o_last;
  - o_err=0.
- 4-bit mode, same frame with one CRC bit flipped on DAT2 -> data words are unchanged; o_done with o_err=1.
- 1-bit mode, end bit driven 0 -> o_done with o_err=1; o_timeout=0.
- i_en dropped after 3 words, then the frame is re-armed and a good 8-byte frame sent:
  - no o_done from the aborted frame;
  - the second frame delivers 2 words and o_err=0.
- With SDIO_RXFRAME_TIMEOUT_EN and LGTIMEOUT=4, DAT held high -> o_done with o_err=1 and o_timeout=1 after 15 strobes. Without the macro, no o_done for 1000 strobes.
